// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts PC fetch requests, reads the word-addressed RAM
// and returns {instr, pc, err} in request order through a small FIFO. Optional macro: IMEM_ALIGN_CHECK_EN.
module imem_fetch_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RSP_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_instr,
    output logic [WIDTH-1:0] rsp_pc,
    output logic             rsp_err,
    input  logic             flush,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_addr,
    input  logic [WIDTH-1:0] ld_data
);

    localparam int MEM_WORDS = 1 << DEPTH_LOG2;
    localparam int PW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW        = $clog2(RSP_DEPTH + 1);
    localparam logic [WIDTH-1:0] NOP_INSTR    = WIDTH'(32'h0000_0013);
    localparam logic [CW:0]      CREDIT_LIMIT = (CW+1)'(RSP_DEPTH);
    localparam logic [PW-1:0]    PTR_LAST     = PW'(RSP_DEPTH - 1);

    logic [WIDTH-1:0] mem [MEM_WORDS];

    logic [WIDTH-1:0] fifo_instr [RSP_DEPTH];
    logic [WIDTH-1:0] fifo_pc    [RSP_DEPTH];
    logic             fifo_err   [RSP_DEPTH];

    logic [CW-1:0]         count_q,    count_d;
    logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic                  inflight_q, inflight_d;
    logic [DEPTH_LOG2-1:0] inf_idx_q,  inf_idx_d;
    logic [WIDTH-1:0]      inf_pc_q,   inf_pc_d;
    logic                  inf_err_q,  inf_err_d;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] ld_idx;
    logic                  req_oor;
    logic                  req_fault;
    logic                  ld_oor;
    logic [CW:0]           credit_used;
    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  unused_addr_lsbs;

    assign req_idx = req_addr[DEPTH_LOG2+1:2];
    assign ld_idx  = ld_addr[DEPTH_LOG2+1:2];
    assign req_oor = |(req_addr >> (DEPTH_LOG2 + 2));
    assign ld_oor  = |(ld_addr >> (DEPTH_LOG2 + 2));

`ifdef IMEM_ALIGN_CHECK_EN
    assign req_fault = req_oor || (req_addr[1:0] != 2'b00);
`else
    assign req_fault = req_oor;
`endif

    assign unused_addr_lsbs = ^{req_addr[1:0], ld_addr[1:0]};

    // Credits cover both buffered entries and the read still in flight, so the FIFO can never overflow.
    assign credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign req_ready   = !rst && !flush && !ld_en && (credit_used < CREDIT_LIMIT);

    assign rsp_valid = !rst && (count_q != '0);
    assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr_q] : '0;
    assign rsp_pc    = rsp_valid ? fifo_pc[rd_ptr_q]    : '0;
    assign rsp_err   = rsp_valid ? fifo_err[rd_ptr_q]   : 1'b0;

    assign accept = req_valid && req_ready;
    assign pop    = rsp_valid && rsp_ready;
    assign push   = inflight_q;

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = accept;
        inf_idx_d  = inf_idx_q;
        inf_pc_d   = inf_pc_q;
        inf_err_d  = inf_err_q;

        if (accept) begin
            inf_idx_d = req_idx;
            inf_pc_d  = req_addr;
            inf_err_d = req_fault;
        end

        if (flush) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            inf_idx_q  <= '0;
            inf_pc_q   <= '0;
            inf_err_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            inf_idx_q  <= inf_idx_d;
            inf_pc_q   <= inf_pc_d;
            inf_err_q  <= inf_err_d;
        end
    end

    // The RAM is read on the edge that returns the data, which gives read-before-write against a load on that edge.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= inf_err_q ? NOP_INSTR : mem[inf_idx_q];
            fifo_pc[wr_ptr_q]    <= inf_pc_q;
            fifo_err[wr_ptr_q]   <= inf_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en && !ld_oor) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed steps then random traffic, checked every cycle
// against a queue model of outstanding responses.
module tb_imem_fetch_responder;

    localparam int RD = 4;
    localparam int NWORDS = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_err;

    imem_fetch_responder #(.WIDTH(32), .DEPTH_LOG2(10), .RSP_DEPTH(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          avail;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [1024];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    function automatic logic addr_fault(input logic [31:0] a);
        logic e;
        e = (a >= 32'h0000_1000);
`ifdef IMEM_ALIGN_CHECK_EN
        e = e || (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: compare outputs with the model, then advance the model across the edge.
    task automatic tick();
        logic m_valid, m_ready, acc, pop;
        exp_t e;
        #1;
        m_valid = !rst && (q.size() > 0) && (q[0].avail <= cyc);
        m_ready = !rst && !flush && !ld_en && (q.size() < RD);
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rsp_instr", rsp_instr, q[0].instr);
            chk("rsp_pc", rsp_pc, q[0].pc);
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end
        acc = m_ready && req_valid;
        pop = m_valid && rsp_ready;
        @(posedge clk);
        cyc++;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.pc    = req_addr;
                e.err   = addr_fault(req_addr);
                e.instr = e.err ? 32'h0000_0013 : mem_m[req_addr[11:2]];
                e.avail = cyc + 1;
                q.push_back(e);
            end
        end
        if (ld_en && (ld_addr < 32'h0000_1000)) mem_m[ld_addr[11:2]] = ld_data;
        @(negedge clk);
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        ld_en = 1'b1;
        ld_addr = 32'(idx) * 4;
        ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic req(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        #1;
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_instr", rsp_instr, 32'd0);
        chk("reset_pc", rsp_pc, 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd1);

        // Program load: words 0..3 fixed, the rest random
        load(0, 32'h11);
        load(1, 32'h22);
        load(2, 32'h33);
        load(3, 32'h44);
        for (int i = 4; i < NWORDS; i++) load(i, $urandom);

        // Back-to-back fetches with the consumer always ready
        rsp_ready = 1'b1;
        req(32'h0);
        req(32'h4);
        req(32'h8);
        req(32'hC);
        idle(3);

        // Backpressure: credits run out after RD accepts
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_addr = 32'(i + 4) * 4;
            tick();
        end
        req_valid = 1'b0;
        idle(2);
        rsp_ready = 1'b1;
        idle(6);

        // Out-of-range and misaligned fetches
        req(32'h0000_1000);
        req(32'h0000_0006);
        req(32'h8000_0004);
        idle(3);

        // Flush with one in flight and two buffered
        rsp_ready = 1'b0;
        req(32'h0);
        req(32'h4);
        req_valid = 1'b1;
        req_addr = 32'h8;
        tick();
        flush = 1'b1;
        req_addr = 32'hC;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        req(32'h20);
        idle(3);

        // Load racing an in-flight read of the same word
        req(32'h14);
        load(5, 32'hDEAD_BEEF);
        req(32'h14);
        idle(3);

        // Reset mid-stream with two responses buffered
        rsp_ready = 1'b0;
        req(32'h4);
        req(32'h8);
        idle(2);
        rst = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h10;
        idle(2);
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(3);
        req(32'h10);
        idle(3);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            req_valid = ($urandom_range(0, 9) < 7);
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 199) == 0);
            ld_en = ($urandom_range(0, 99) < 6);
            r = $urandom_range(0, 9);
            if (r == 0) req_addr = 32'h0000_1000 | ($urandom & 32'hFFFF_FFFC);
            else if (r == 1) req_addr = 32'($urandom_range(0, NWORDS - 1)) * 4 + 32'($urandom_range(1, 3));
            else req_addr = 32'($urandom_range(0, NWORDS - 1)) * 4;
            if ($urandom_range(0, 4) == 0) ld_addr = 32'h0000_1000 + 32'($urandom_range(0, NWORDS - 1)) * 4;
            else ld_addr = 32'($urandom_range(0, NWORDS - 1)) * 4;
            ld_data = $urandom;
            tick();
        end
        req_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        ld_en = 1'b0;
        rsp_ready = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
